// File: rtl/seg7_if.sv
// Load bus for the 7-segment controller: one valid/ready handshake carrying
// a whole display image (digits, decimal points, blink mask, blanking, brightness).
interface seg7_if #(
    parameter int N_DIGITS = 6,
    parameter int PWM_BITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*N_DIGITS-1:0] in_data;
    logic [N_DIGITS-1:0]   in_dp;
    logic [N_DIGITS-1:0]   in_blink;
    logic                  in_lzb;
    logic [PWM_BITS-1:0]   in_bright;

    modport master (output in_valid, in_data, in_dp, in_blink, in_lzb, in_bright,
                    input  in_ready);
    modport slave  (input  in_valid, in_data, in_dp, in_blink, in_lzb, in_bright,
                    output in_ready);
endinterface

// File: rtl/seg7_ctrl.sv
// N-digit 7-segment controller: shadow load -> decode stage -> gated output register
// driving active-low {dp,g,f,e,d,c,b,a} segments with blanking, blink and PWM dimming.
module seg7_digit (
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    logic [6:0] code;

    always_comb begin
        code = 7'h7F;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            4'hF: code = 7'h0E;
            default: code = 7'h7F;
        endcase
    end

    // A blanked digit keeps its decimal point.
    assign seg = {~dp, blank ? 7'h7F : code};
endmodule

module seg7_ctrl #(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25_000_000,
    parameter int PWM_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_if.slave                 bus,
    output logic [8*N_DIGITS-1:0] hex
);
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef struct packed {
        logic [N_DIGITS-1:0][3:0] nib;
        logic [N_DIGITS-1:0]      dp;
        logic [N_DIGITS-1:0]      blink;
        logic                     lzb;
        logic [PWM_BITS-1:0]      bright;
    } ld_t;

    typedef struct packed {
        logic [N_DIGITS-1:0][7:0] seg;
        logic [N_DIGITS-1:0]      blink;
        logic [PWM_BITS-1:0]      bright;
    } dec_t;

    ld_t                      shd;
    dec_t                     dec;
    logic                     shd_vld, loaded, rdy, acc;
    logic [BW-1:0]            bcnt;
    logic                     phase;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [N_DIGITS:0]        zhi;
    logic [N_DIGITS-1:0][7:0] seg_d, gated;
    logic                     en;

    assign bus.in_ready = rdy;
    assign acc          = bus.in_valid & rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy     <= 1'b0;
            shd     <= '0;
            shd_vld <= 1'b0;
            dec     <= '0;
            loaded  <= 1'b0;
        end else begin
            rdy     <= ~acc;
            shd_vld <= acc;
            if (acc) begin
                shd.nib    <= bus.in_data;
                shd.dp     <= bus.in_dp;
                shd.blink  <= bus.in_blink;
                shd.lzb    <= bus.in_lzb;
                shd.bright <= bus.in_bright;
            end
            if (shd_vld) begin
                dec.seg    <= seg_d;
                dec.blink  <= shd.blink;
                dec.bright <= shd.bright;
                loaded     <= 1'b1;
            end
        end
    end

    // zhi[i]: digit i and all digits above it are zero.
    assign zhi[N_DIGITS] = 1'b1;
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
        logic blank;
        assign zhi[i] = zhi[i+1] & (shd.nib[i] == 4'h0);
        if (i == 0) begin : g_lsd
            assign blank = 1'b0;
        end else begin : g_hi
            assign blank = shd.lzb & zhi[i];
        end
        seg7_digit u_dig (.nib(shd.nib[i]), .dp(shd.dp[i]), .blank(blank), .seg(seg_d[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt    <= '0;
            phase   <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    assign en = (pwm_cnt < dec.bright) | (&dec.bright);

    always_comb begin
        gated = '1;
        for (int i = 0; i < N_DIGITS; i++)
            if (loaded && en && !(dec.blink[i] && phase))
                gated[i] = dec.seg[i];
    end

    always_ff @(posedge clk) begin
        if (rst) hex <= '1;
        else     hex <= gated;
    end
endmodule

// File: tb/tb_seg7_ctrl.sv
// Randomized + directed bench for seg7_ctrl against an edge-count based reference model.
module tb_seg7_ctrl;
    localparam int ND = 6;
    localparam int BD = 4;
    localparam int PB = 2;

    logic clk = 1'b0;
    logic rst;
    logic [8*ND-1:0] hex;

    seg7_if #(.N_DIGITS(ND), .PWM_BITS(PB)) bus ();
    seg7_ctrl #(.N_DIGITS(ND), .BLINK_DIV(BD), .PWM_BITS(PB)) dut (
        .clk(clk), .rst(rst), .bus(bus), .hex(hex));

    always #5 clk = ~clk;

    typedef struct {
        int         acc;
        logic [23:0] d;
        logic [5:0] dp;
        logic [5:0] bl;
        logic       lz;
        logic [1:0] br;
    } ld_t;

    ld_t  q[$];
    int   n = 0;
    bit   exp_rdy = 0;
    bit   seen_rst = 0;
    int   checks = 0, errors = 0;
    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Display after n edges since reset: newest load at least 2 edges old,
    // gated by the counters as they stood one edge earlier.
    function automatic logic [47:0] exp_hex();
        int   idx = -1;
        int   ph, pw;
        bit   en, allz;
        logic [47:0] r = '1;
        logic [3:0] nb;
        logic [7:0] c;
        for (int j = 0; j < q.size(); j++) if (q[j].acc <= n - 2) idx = j;
        if (n == 0 || idx < 0) return r;
        ph = ((n - 1) / BD) % 2;
        pw = (n - 1) % (1 << PB);
        en = (pw < int'(q[idx].br)) || (q[idx].br == 2'd3);
        if (!en) return r;
        for (int i = 0; i < ND; i++) begin
            nb = q[idx].d[4*i +: 4];
            allz = 1;
            for (int j = i; j < ND; j++) if (q[idx].d[4*j +: 4] != 0) allz = 0;
            if (q[idx].lz && i > 0 && allz) c = 8'hFF;
            else                            c = tbl[nb];
            if (q[idx].dp[i]) c[7] = 1'b0;
            if (q[idx].bl[i] && ph == 1) c = 8'hFF;
            r[8*i +: 8] = c;
        end
        return r;
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [23:0] d,
                       input logic [5:0] dp, input logic [5:0] bl,
                       input logic lz, input logic [1:0] br);
        ld_t l;
        @(negedge clk);
        if (seen_rst) begin
            chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            chk("hex", 64'(hex), 64'(exp_hex()));
        end
        rst = r;
        bus.in_valid = v; bus.in_data = d; bus.in_dp = dp;
        bus.in_blink = bl; bus.in_lzb = lz; bus.in_bright = br;
        if (r) begin
            n = 0; q.delete(); exp_rdy = 0; seen_rst = 1;
        end else begin
            n++;
            if (v && exp_rdy) begin
                l.acc = n; l.d = d; l.dp = dp; l.bl = bl; l.lz = lz; l.br = br;
                q.push_back(l);
                if (q.size() > 8) void'(q.pop_front());
                exp_rdy = 0;
            end else begin
                exp_rdy = 1;
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 24'h0, 6'h0, 6'h0, 0, 2'd3);
    endtask

    task automatic load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl,
                        input logic lz, input logic [1:0] br);
        while (!exp_rdy) idle(1);
        cyc(0, 1, d, dp, bl, lz, br);
    endtask

    function automatic logic [23:0] rnd_data();
        logic [23:0] d;
        for (int i = 0; i < ND; i++) d[4*i +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
        return d;
    endfunction

    initial begin
        rst = 1'b1;
        bus.in_valid = 0; bus.in_data = 0; bus.in_dp = 0;
        bus.in_blink = 0; bus.in_lzb = 0; bus.in_bright = 0;
        // reset with in_valid asserted, which must be ignored
        for (int i = 0; i < 3; i++) cyc(1, 1, 24'h123456, 6'h0, 6'h0, 0, 2'd3);
        idle(2);
        load(24'h012345, 6'h00, 6'h00, 0, 2'd3); idle(4);
        load(24'h00000A, 6'h04, 6'h00, 1, 2'd3); idle(4);
        load(24'h000000, 6'h00, 6'h00, 1, 2'd3); idle(4);
        load(24'h111111, 6'h00, 6'h01, 0, 2'd3); idle(20);
        load(24'h012345, 6'h00, 6'h00, 0, 2'd1); idle(12);
        load(24'h012345, 6'h00, 6'h00, 0, 2'd0); idle(8);
        load(24'h012345, 6'h00, 6'h00, 0, 2'd3); idle(8);
        for (int i = 0; i < 12; i++) cyc(0, 1, 24'(i * 24'h111111), 6'h0, 6'h0, 0, 2'd3);
        idle(4);
        load(24'hABCDEF, 6'h3F, 6'h00, 0, 2'd3);
        cyc(1, 0, 24'h0, 6'h0, 6'h0, 0, 2'd3);
        idle(6);
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 60) == 0, ($urandom % 3) != 0, rnd_data(),
                6'($urandom), 6'(($urandom % 4 == 0) ? $urandom : 0),
                1'($urandom), 2'($urandom));
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
